// File: rtl/if_stage_pkg.sv
// Shared constants and types for the instruction-fetch stage: bus layout, reset vector,
// stall-vector bit positions and the next-PC selection encoding.
package if_stage_pkg;

  localparam int unsigned FS_TO_DS_BUS_WD = 34;
  localparam logic [31:0] RESET_PC        = 32'h1c00_0000;

  localparam int unsigned STALL_IF = 0;
  localparam int unsigned STALL_ID = 1;

  // Bit order matches fs2_to_ds_bus: {pc_valid, excp_adef, pc}
  typedef struct packed {
    logic        valid;
    logic        adef;
    logic [31:0] pc;
  } fs2_t;

  typedef enum logic [2:0] {
    NPC_RESET,
    NPC_FLUSH,
    NPC_BR_SQUASH,
    NPC_BR_HOLD,
    NPC_STALL,
    NPC_SEQ
  } npc_sel_e;

  function automatic logic misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/if_stage.sv
// Instruction-fetch stage: issues the fetch PC to the synchronous inst SRAM and tracks the
// in-flight fetch in fs2 so its {valid, adef, pc} lines up with rdata at the ID capture edge.
module if_stage #(
  parameter int unsigned FS_TO_DS_BUS_WD = if_stage_pkg::FS_TO_DS_BUS_WD,
  parameter logic [31:0] RESET_PC        = if_stage_pkg::RESET_PC
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic [31:0]                new_pc,
  input  logic [5:0]                 stall,
  input  logic                       br_taken,
  input  logic [31:0]                br_target,
  output logic                       inst_sram_en,
  output logic [3:0]                 inst_sram_we,
  output logic [31:0]                inst_sram_addr,
  output logic [31:0]                inst_sram_wdata,
  output logic [FS_TO_DS_BUS_WD-1:0] fs2_to_ds_bus
);

  import if_stage_pkg::*;

  logic [31:0] r_pc;
  fs2_t        r_fs2;
  npc_sel_e    w_sel;
  logic        w_stall_if;
  logic        w_unused_stall;

  assign w_stall_if     = stall[STALL_IF];
  assign w_unused_stall = ^stall[5:STALL_ID];

  always_comb begin
    w_sel = NPC_SEQ;
    if (reset)            w_sel = NPC_RESET;
    else if (flush)       w_sel = NPC_FLUSH;
    else if (br_taken)    w_sel = w_stall_if ? NPC_BR_HOLD : NPC_BR_SQUASH;
    else if (w_stall_if)  w_sel = NPC_STALL;
  end

  // A stalled branch keeps the wrong-path fetch in fs2; ID squashes it on its own br_taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc  <= RESET_PC;
      r_fs2 <= '0;
    end else begin
      case (w_sel)
        NPC_FLUSH: begin
          r_pc  <= new_pc;
          r_fs2 <= '0;
        end
        NPC_BR_SQUASH: begin
          r_pc  <= br_target;
          r_fs2 <= '0;
        end
        NPC_BR_HOLD: begin
          r_pc <= br_target;
        end
        NPC_SEQ: begin
          r_fs2.valid <= 1'b1;
          r_fs2.adef  <= misaligned(r_pc);
          r_fs2.pc    <= r_pc;
          r_pc        <= r_pc + 32'd4;
        end
        default: begin
        end
      endcase
    end
  end

  // A misaligned PC never reaches the SRAM; it still flows into fs2 flagged as ADEF.
  always_comb begin
    inst_sram_en    = !reset && !flush && !br_taken && !w_stall_if && !misaligned(r_pc);
    inst_sram_we    = '0;
    inst_sram_addr  = r_pc;
    inst_sram_wdata = '0;
  end

  assign fs2_to_ds_bus = r_fs2;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios with literal expectations plus a
// randomized phase, all cross-checked every cycle against a behavioural fetch model.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic [31:0] new_pc;
  logic [5:0]  stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [33:0] fs2_to_ds_bus;

  int n_cmp = 0;
  int n_err = 0;

  if_stage #(.FS_TO_DS_BUS_WD(34), .RESET_PC(32'h1c00_0000)) dut (
    .clk             (clk),
    .reset           (reset),
    .flush           (flush),
    .new_pc          (new_pc),
    .stall           (stall),
    .br_taken        (br_taken),
    .br_target       (br_target),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_we    (inst_sram_we),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .fs2_to_ds_bus   (fs2_to_ds_bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: the next fetch address and the fetch whose data is returning now.
  bit          m_ok = 1'b0;
  logic [31:0] m_pc;
  logic        m_v, m_a;
  logic [31:0] m_fpc;

  always @(posedge clk) begin
    if (reset) begin
      m_ok = 1'b1;
      m_pc = 32'h1c00_0000;
      {m_v, m_a, m_fpc} = '0;
    end else if (flush) begin
      m_pc = new_pc;
      {m_v, m_a, m_fpc} = '0;
    end else if (br_taken) begin
      if (!stall[0]) {m_v, m_a, m_fpc} = '0;
      m_pc = br_target;
    end else if (!stall[0]) begin
      m_v   = 1'b1;
      m_a   = (m_pc % 4) != 0;
      m_fpc = m_pc;
      m_pc  = m_pc + 32'd4;
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("en",    64'(inst_sram_en),
          64'(!reset && !flush && !br_taken && !stall[0] && (m_pc % 4 == 0)));
      chk("addr",  64'(inst_sram_addr), 64'(m_pc));
      chk("bus",   64'(fs2_to_ds_bus), 64'({m_v, m_a, m_fpc}));
      chk("we",    64'(inst_sram_we), 64'd0);
      chk("wdata", 64'(inst_sram_wdata), 64'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 7))
      0:       r = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3)) * 4;
      1:       r[1:0] = 2'($urandom_range(1, 3));
      default: r[1:0] = 2'b00;
    endcase
    return r;
  endfunction

  initial begin
    reset = 1'b1; flush = 1'b0; new_pc = '0; stall = '0; br_taken = 1'b0; br_target = '0;

    // Reset and sequential fetch
    repeat (3) step();
    @(negedge clk);
    chk("rst_en", 64'(inst_sram_en), 64'd0);
    chk("rst_bus", 64'(fs2_to_ds_bus), 64'd0);
    step(); reset = 1'b0;
    @(negedge clk);
    chk("seq0_addr", 64'(inst_sram_addr), 64'h1c00_0000);
    chk("seq0_en", 64'(inst_sram_en), 64'd1);
    chk("seq0_bus", 64'(fs2_to_ds_bus), 64'd0);
    step(); @(negedge clk);
    chk("seq1_addr", 64'(inst_sram_addr), 64'h1c00_0004);
    chk("seq1_bus", 64'(fs2_to_ds_bus), 64'h2_1c00_0000);
    step(); @(negedge clk);
    chk("seq2_addr", 64'(inst_sram_addr), 64'h1c00_0008);
    chk("seq2_bus", 64'(fs2_to_ds_bus), 64'h2_1c00_0004);

    // Branch redirect
    step(); br_taken = 1'b1; br_target = 32'h1c00_0100;
    @(negedge clk);
    chk("br_en", 64'(inst_sram_en), 64'd0);
    step(); br_taken = 1'b0;
    @(negedge clk);
    chk("br_addr", 64'(inst_sram_addr), 64'h1c00_0100);
    chk("br_bus", 64'(fs2_to_ds_bus), 64'd0);
    step(); @(negedge clk);
    chk("br_bus2", 64'(fs2_to_ds_bus), 64'h2_1c00_0100);

    // Stall for 3 cycles at 1c000010
    step(); br_taken = 1'b1; br_target = 32'h1c00_0008;
    step(); br_taken = 1'b0;
    step();
    step(); stall = 6'b000001;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stl_en", 64'(inst_sram_en), 64'd0);
      chk("stl_addr", 64'(inst_sram_addr), 64'h1c00_0010);
      chk("stl_bus", 64'(fs2_to_ds_bus), 64'h2_1c00_000c);
      step();
    end
    stall = '0;
    @(negedge clk);
    chk("res_en", 64'(inst_sram_en), 64'd1);
    chk("res_addr", 64'(inst_sram_addr), 64'h1c00_0010);
    step(); @(negedge clk);
    chk("res_addr2", 64'(inst_sram_addr), 64'h1c00_0014);
    chk("res_bus2", 64'(fs2_to_ds_bus), 64'h2_1c00_0010);

    // Flush and branch together: flush wins
    step(); flush = 1'b1; br_taken = 1'b1; new_pc = 32'h1c00_8000; br_target = 32'h1c00_0200;
    @(negedge clk);
    chk("fl_en", 64'(inst_sram_en), 64'd0);
    step(); flush = 1'b0; br_taken = 1'b0;
    @(negedge clk);
    chk("fl_addr", 64'(inst_sram_addr), 64'h1c00_8000);
    chk("fl_bus", 64'(fs2_to_ds_bus), 64'd0);

    // Misaligned target -> ADEF, keeps incrementing until flush
    step(); br_taken = 1'b1; br_target = 32'h1c00_0102;
    step(); br_taken = 1'b0;
    @(negedge clk);
    chk("adef_en", 64'(inst_sram_en), 64'd0);
    chk("adef_addr", 64'(inst_sram_addr), 64'h1c00_0102);
    step(); @(negedge clk);
    chk("adef_bus", 64'(fs2_to_ds_bus), 64'h3_1c00_0102);
    chk("adef_addr2", 64'(inst_sram_addr), 64'h1c00_0106);
    step(); flush = 1'b1; new_pc = 32'h1c00_1000;
    step(); flush = 1'b0;
    @(negedge clk);
    chk("adef_fl_addr", 64'(inst_sram_addr), 64'h1c00_1000);
    chk("adef_fl_en", 64'(inst_sram_en), 64'd1);

    // Reset during a stall at 1c000040
    step(); br_taken = 1'b1; br_target = 32'h1c00_003c;
    step(); br_taken = 1'b0;
    step(); stall = 6'b000001;
    @(negedge clk);
    chk("rs_addr", 64'(inst_sram_addr), 64'h1c00_0040);
    step(); reset = 1'b1;
    @(negedge clk);
    chk("rs_en", 64'(inst_sram_en), 64'd0);
    step(); reset = 1'b0; stall = '0;
    @(negedge clk);
    chk("rs_addr2", 64'(inst_sram_addr), 64'h1c00_0000);
    chk("rs_bus", 64'(fs2_to_ds_bus), 64'd0);

    // 32-bit wrap
    step(); br_taken = 1'b1; br_target = 32'hFFFF_FFF8;
    step(); br_taken = 1'b0;
    step(); step();
    @(negedge clk);
    chk("wrap_addr", 64'(inst_sram_addr), 64'h0000_0000);
    chk("wrap_bus", 64'(fs2_to_ds_bus), 64'h2_FFFF_FFFC);

    // Randomized traffic, checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      step();
      reset     = ($urandom_range(0, 63) == 0);
      flush     = ($urandom_range(0, 15) == 0);
      br_taken  = ($urandom_range(0, 7) == 0);
      stall     = 6'($urandom_range(0, 63));
      stall[0]  = ($urandom_range(0, 3) == 0);
      new_pc    = rand_addr();
      br_target = rand_addr();
    end
    step();
    reset = 1'b0; flush = 1'b0; br_taken = 1'b0; stall = '0;
    repeat (3) step();
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
